// File: rtl/aes_round_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | aes_round_ctrl: sequences the 32-bit-radix AES round datapath for one  |
// | 128-bit block per transaction. Revision: 1.0                           |
// +------------------------------------------------------------------------+
module aes_round_ctrl (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  input  logic [1:0]   in_mode,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         out_err,
  output logic [3:0]   rd_round,
  output logic [1:0]   rd_mode,
  output logic [2:0]   rd_width_sel,
  output logic [127:0] rd_data_in,
  input  logic [127:0] rd_data_out
);

  localparam logic [3:0] c_NR_128 = 4'd10;
  localparam logic [3:0] c_NR_256 = 4'd14;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ROUND0 = 3'd1,
    S_WORD   = 3'd2,
    S_LATCH  = 3'd3,
    S_DONE   = 3'd4
  } fsm_t;

  fsm_t         r_fsm, w_fsm_nxt;
  logic [127:0] r_blk, w_blk_nxt;
  logic [1:0]   r_mode, w_mode_nxt;
  logic [3:0]   r_round, w_round_nxt;
  logic [1:0]   r_sel, w_sel_nxt;
  logic [127:0] r_out_data, w_out_data_nxt;
  logic         r_out_err, w_out_err_nxt;
  logic [3:0]   w_last_round;

  assign w_last_round = (r_mode == 2'b10) ? c_NR_256 : c_NR_128;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_fsm      <= S_IDLE;
      r_blk      <= '0;
      r_mode     <= '0;
      r_round    <= '0;
      r_sel      <= '0;
      r_out_data <= '0;
      r_out_err  <= 1'b0;
    end else begin
      r_fsm      <= w_fsm_nxt;
      r_blk      <= w_blk_nxt;
      r_mode     <= w_mode_nxt;
      r_round    <= w_round_nxt;
      r_sel      <= w_sel_nxt;
      r_out_data <= w_out_data_nxt;
      r_out_err  <= w_out_err_nxt;
    end
  end

  always_comb begin
    w_fsm_nxt      = r_fsm;
    w_blk_nxt      = r_blk;
    w_mode_nxt     = r_mode;
    w_round_nxt    = r_round;
    w_sel_nxt      = r_sel;
    w_out_data_nxt = r_out_data;
    w_out_err_nxt  = r_out_err;
    case (r_fsm)
      S_IDLE: begin
        if (in_valid) begin
          // Odd mode codes are unsupported and bypass the datapath entirely
          if (!in_mode[0]) begin
            w_blk_nxt   = in_data;
            w_mode_nxt  = in_mode;
            w_round_nxt = 4'd0;
            w_fsm_nxt   = S_ROUND0;
          end else begin
            w_out_data_nxt = '0;
            w_out_err_nxt  = 1'b1;
            w_fsm_nxt      = S_DONE;
          end
        end
      end
      S_ROUND0: begin
        w_blk_nxt   = rd_data_out;
        w_round_nxt = 4'd1;
        w_sel_nxt   = 2'd0;
        w_fsm_nxt   = S_WORD;
      end
      S_WORD: begin
        w_sel_nxt = r_sel + 2'd1;
        if (r_sel == 2'd3) begin
          w_fsm_nxt = S_LATCH;
        end
      end
      S_LATCH: begin
        w_blk_nxt = rd_data_out;
        if (r_round == w_last_round) begin
          w_out_data_nxt = rd_data_out;
          w_out_err_nxt  = 1'b0;
          w_fsm_nxt      = S_DONE;
        end else begin
          w_round_nxt = r_round + 4'd1;
          w_sel_nxt   = 2'd0;
          w_fsm_nxt   = S_WORD;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          w_fsm_nxt = S_IDLE;
        end
      end
      default: w_fsm_nxt = S_IDLE;
    endcase
  end

  assign in_ready     = (r_fsm == S_IDLE);
  assign out_valid    = (r_fsm == S_DONE);
  assign out_data     = r_out_data;
  assign out_err      = r_out_err;
  assign rd_mode      = r_mode;
  assign rd_data_in   = r_blk;
  assign rd_width_sel = (r_fsm == S_WORD) ? {1'b0, r_sel} : 3'd0;
  assign rd_round     = (r_fsm == S_ROUND0 || r_fsm == S_WORD || r_fsm == S_LATCH)
                        ? r_round : 4'd0;

endmodule
`default_nettype wire

// File: tb/tb_aes_round_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_aes_round_ctrl: bench with an AES round datapath/key-store model.   |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module tb_aes_round_ctrl;

  logic         clk = 1'b0;
  logic         reset, in_valid, in_ready, out_valid, out_ready, out_err;
  logic [127:0] in_data, out_data, rd_data_in, rd_data_out;
  logic [1:0]   in_mode, rd_mode;
  logic [3:0]   rd_round;
  logic [2:0]   rd_width_sel;

  always #5 clk = ~clk;

  aes_round_ctrl dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_mode(in_mode), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_err(out_err),
    .rd_round(rd_round), .rd_mode(rd_mode), .rd_width_sel(rd_width_sel),
    .rd_data_in(rd_data_in), .rd_data_out(rd_data_out)
  );

  // ---------------- AES primitives ----------------
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00; x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] r, b;
    int e;
    r = 8'h01; b = a; e = 254;
    while (e != 0) begin
      if (e % 2 == 1) r = gmul(r, b);
      b = gmul(b, b);
      e = e / 2;
    end
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
  endfunction

  // One output column: SubBytes + ShiftRows, plus MixColumns unless final round
  function automatic logic [31:0] col_out(input logic [127:0] s, input logic [1:0] c, input logic fin);
    logic [7:0] a [4];
    for (int r = 0; r < 4; r++) a[r] = sbox(s[127 - 8*(4*((int'(c) + r) % 4) + r) -: 8]);
    if (fin) return {a[0], a[1], a[2], a[3]};
    return {xt(a[0]) ^ xt(a[1]) ^ a[1] ^ a[2] ^ a[3],
            a[0] ^ xt(a[1]) ^ xt(a[2]) ^ a[2] ^ a[3],
            a[0] ^ a[1] ^ xt(a[2]) ^ xt(a[3]) ^ a[3],
            xt(a[0]) ^ a[0] ^ a[1] ^ a[2] ^ xt(a[3])};
  endfunction

  function automatic logic [31:0] subword(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  logic [127:0] rk128 [16];
  logic [127:0] rk256 [16];

  task automatic expand(input logic [255:0] key, input int nk, input bit is256);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < nk; i++) w[i] = key[255 - 32*i -: 32];
    for (int i = nk; i < 4*(nk + 7); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t = subword({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = xt(rc);
      end else if (nk > 4 && i % nk == 4) begin
        t = subword(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    for (int r = 0; r < 16; r++) begin
      if (is256) rk256[r] = (r <= nk + 6) ? {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]} : '0;
      else       rk128[r] = (r <= nk + 6) ? {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]} : '0;
    end
  endtask

  function automatic logic [127:0] aes_ref(input logic [127:0] pt, input logic [1:0] m);
    logic [127:0] s;
    int nr;
    if (m[0]) return '0;
    nr = (m == 2'b10) ? 14 : 10;
    s = pt ^ ((m == 2'b10) ? rk256[0] : rk128[0]);
    for (int r = 1; r <= nr; r++) begin
      s = {col_out(s, 2'd0, r == nr), col_out(s, 2'd1, r == nr),
           col_out(s, 2'd2, r == nr), col_out(s, 2'd3, r == nr)}
          ^ ((m == 2'b10) ? rk256[r] : rk128[r]);
    end
    return s;
  endfunction

  // ---------------- datapath + key store model ----------------
  logic [31:0]  acc [4];
  logic [127:0] cur_key;

  always_ff @(posedge clk)
    acc[rd_width_sel[1:0]] <= col_out(rd_data_in, rd_width_sel[1:0],
                                      rd_round == ((rd_mode == 2'b10) ? 4'd14 : 4'd10));

  always_comb begin
    cur_key = (rd_mode == 2'b10) ? rk256[rd_round] : rk128[rd_round];
    if (rd_round == 4'd0) rd_data_out = rd_data_in ^ cur_key;
    else                  rd_data_out = {acc[0], acc[1], acc[2], acc[3]} ^ cur_key;
  end

  // ---------------- checking infrastructure ----------------
  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input bit ok, input string name, input logic [127:0] act, input logic [127:0] exp_v);
    n_chk++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
  endtask

  typedef struct {
    logic [127:0] pt;
    logic [1:0]   mode;
    int           hold;
    logic         err;
    logic [127:0] ct;
    int           lat;
  } vec_t;

  typedef struct {
    logic         err;
    logic [127:0] data;
  } exp_t;

  vec_t tbl [6];
  exp_t sb [$];

  task automatic check_idle_reset();
    check(in_ready == 1'b1,       "rst_in_ready",  in_ready, 1);
    check(out_valid == 1'b0,      "rst_out_valid", out_valid, 0);
    check(out_err == 1'b0,        "rst_out_err",   out_err, 0);
    check(out_data == '0,         "rst_out_data",  out_data, 0);
    check(rd_round == 4'd0,       "rst_rd_round",  rd_round, 0);
    check(rd_mode == 2'd0,        "rst_rd_mode",   rd_mode, 0);
    check(rd_width_sel == 3'd0,   "rst_width_sel", rd_width_sel, 0);
    check(rd_data_in == '0,       "rst_data_in",   rd_data_in, 0);
  endtask

  // Drive a block and wait for the accept edge; on return we sit 1 ns after it
  task automatic accept(input logic [127:0] pt, input logic [1:0] m);
    int g;
    exp_t e;
    in_data = pt; in_mode = m; in_valid = 1'b1; g = 0;
    while (!in_ready && g < 300) begin
      @(posedge clk); #1; g++;
    end
    check(in_ready, "accept_ready", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    e.err = m[0]; e.data = aes_ref(pt, m);
    sb.push_back(e);
  endtask

  task automatic run_vec(input vec_t v);
    int cnt, bad, hb, j, er, es;
    logic [127:0] prev_din, held;
    exp_t e;
    accept(v.pt, v.mode);
    cnt = 0; bad = 0; prev_din = rd_data_in;
    while (!out_valid && cnt < 200) begin
      if (cnt == 0) begin er = 0; es = 0; end
      else begin j = cnt - 1; er = j / 5 + 1; es = (j % 5 < 4) ? j % 5 : 0; end
      if (rd_round != 4'(er) || rd_width_sel != 3'(es) || rd_mode != v.mode || in_ready) bad++;
      if (cnt == 0 && rd_data_in != v.pt) bad++;
      // state may only move on the edge leaving ROUND0 or a LATCH cycle
      if (cnt > 0 && rd_data_in != prev_din && !(cnt == 1 || (cnt - 2) % 5 == 4)) bad++;
      prev_din = rd_data_in;
      @(posedge clk); #1; cnt++;
    end
    check(out_valid, "done_timeout", out_valid, 1);
    check(cnt == v.lat, "latency", cnt, v.lat);
    if (!v.err) check(bad == 0, "trace", bad, 0);
    check(rd_round == 4'd0 && rd_width_sel == 3'd0 && !in_ready, "done_outputs",
          {rd_round, rd_width_sel, in_ready}, 0);
    held = out_data; hb = 0;
    for (int h = 0; h < v.hold; h++) begin
      if (h == 2) begin in_valid = 1'b1; in_data = ~v.pt; in_mode = 2'b00; end
      if (h == 5) in_valid = 1'b0;
      if (!out_valid || out_data != held || in_ready || rd_round != 4'd0) hb++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    if (v.hold > 0) check(hb == 0, "backpressure_hold", hb, 0);
    out_ready = 1'b1;
    if (sb.size() == 0) begin
      check(1'b0, "scoreboard_empty", 0, 1);
    end else begin
      e = sb.pop_front();
      check(out_err == e.err, "out_err", out_err, e.err);
      check(out_data == e.data, "out_data_model", out_data, e.data);
    end
    check(out_data == v.ct, "out_data_vector", out_data, v.ct);
    @(posedge clk); #1;
    out_ready = 1'b0;
    check(!out_valid && in_ready, "release", {out_valid, in_ready}, 2'b01);
  endtask

  localparam logic [127:0] c_PT = 128'h00112233445566778899aabbccddeeff;

  initial begin
    int cnt, ov;
    reset = 1'b1; in_valid = 1'b0; in_data = '0; in_mode = 2'b00; out_ready = 1'b0;
    expand({128'h000102030405060708090a0b0c0d0e0f, 128'h0}, 4, 1'b0);
    expand(256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, 8, 1'b1);

    tbl[0] = '{c_PT, 2'b00, 0, 1'b0, 128'h69c4e0d86a7b0430d8cdb78070b4c55a, 51};
    tbl[1] = '{c_PT, 2'b10, 0, 1'b0, 128'h8ea2b7ca516745bfeafc49904b496089, 71};
    // unsupported modes go to DONE on the accept edge itself
    tbl[2] = '{c_PT, 2'b01, 3, 1'b1, 128'h0, 0};
    tbl[3] = '{c_PT, 2'b11, 0, 1'b1, 128'h0, 0};
    tbl[4] = '{128'h3243f6a8885a308d313198a2e0370734, 2'b00, 10, 1'b0, 128'h0, 51};
    tbl[5] = '{{$urandom(), $urandom(), $urandom(), $urandom()}, 2'b10, 4, 1'b0, 128'h0, 71};
    tbl[4].ct = aes_ref(tbl[4].pt, tbl[4].mode);
    tbl[5].ct = aes_ref(tbl[5].pt, tbl[5].mode);

    repeat (3) @(posedge clk);
    #1;
    check_idle_reset();
    reset = 1'b0;

    for (int i = 0; i < 6; i++) run_vec(tbl[i]);

    // Abort an AES-128 run at round 6, sel 2
    accept(c_PT, 2'b00);
    cnt = 0;
    while (cnt < 28) begin @(posedge clk); #1; cnt++; end
    check(rd_round == 4'd6 && rd_width_sel == 3'd2, "reset_point", {rd_round, rd_width_sel}, {4'd6, 3'd2});
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    sb.delete();
    check_idle_reset();
    out_ready = 1'b1;
    ov = 0;
    for (int i = 0; i < 100; i++) begin
      if (out_valid || !in_ready) ov++;
      @(posedge clk); #1;
    end
    out_ready = 1'b0;
    check(ov == 0, "no_output_after_reset", ov, 0);
    run_vec(tbl[0]);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
